// File: rtl/glenn_uart_rx.sv
// ---------------------------------------------------------------------------
// glenn_uart_rx
//
// UART receiver, 8N1, LSB first. The serial line is passed through a
// two-flop synchroniser. The start bit is confirmed at mid-bit. Eight data
// bits and the stop bit are then sampled once per bit period, at the same
// mid-bit phase. A good frame updates the held byte and pulses
// out_Rx_Valid for one cycle. A stop bit sampled low pulses
// out_Rx_Frame_Err for one cycle instead, and the held byte is unchanged.
//
// Parameters
//   CLKS_PER_BIT     clock frequency / baud rate, legal range 1..255
//
// Ports
//   in_UART_Clock     in   1  single clock, rising edge
//   in_Reset_n        in   1  asynchronous, active-low reset
//   in_Rx_Serial      in   1  serial line (idle 1, start 0, stop 1)
//   out_Rx_8bitData   out  8  last good byte, held until the next good frame
//   out_Rx_Valid      out  1  1-cycle pulse: out_Rx_8bitData newly valid
//   out_Rx_Active     out  1  high while a frame is in progress
//   out_Rx_Frame_Err  out  1  1-cycle pulse: stop bit sampled as 0
// ---------------------------------------------------------------------------
module glenn_uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       in_UART_Clock,
  input  logic       in_Reset_n,
  input  logic       in_Rx_Serial,
  output logic [7:0] out_Rx_8bitData,
  output logic       out_Rx_Valid,
  output logic       out_Rx_Active,
  output logic       out_Rx_Frame_Err
);

  // This value is derived from CLKS_PER_BIT and must not be overridden.
  // It is therefore a localparam and not a module parameter.
  localparam int         HALF_BIT   = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0] LAST_CNT   = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF_CNT   = 8'(HALF_BIT);
  // At one or two clocks per bit there is no mid-bit wait for the start bit.
  // In that case the receiver goes straight from IDLE into the data phase.
  localparam bit         SKIP_START = (HALF_BIT == 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [7:0] shift_data_reg, shift_data_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       valid_reg, valid_next;
  logic       frame_err_reg, frame_err_next;
  logic       sync1_reg, sync2_reg;
  logic       line;

  // The two synchroniser flops reset to 1, which is the idle line level.
  // A reset therefore cannot make the receiver see a false start bit.
  always_ff @(posedge in_UART_Clock or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= in_Rx_Serial;
      sync2_reg <= sync1_reg;
    end
  end

  assign line = sync2_reg;

  // State and datapath registers
  always_ff @(posedge in_UART_Clock or negedge in_Reset_n) begin
    if (!in_Reset_n) begin
      state_reg      <= IDLE;
      clk_cnt_reg    <= 8'd0;
      bit_idx_reg    <= 3'd0;
      shift_data_reg <= 8'd0;
      rx_data_reg    <= 8'd0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clk_cnt_reg    <= clk_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_data_reg <= shift_data_next;
      rx_data_reg    <= rx_data_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  // Next-state and datapath logic.
  // The counters only count up from 0 or 1 to their terminal value.
  // An equality test is therefore enough to detect the terminal count.
  always_comb begin
    state_next      = state_reg;
    clk_cnt_next    = clk_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_data_next = shift_data_reg;
    rx_data_next    = rx_data_reg;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!line) begin
          if (SKIP_START) begin
            state_next   = DATA;
            clk_cnt_next = 8'd0;
            bit_idx_next = 3'd0;
          end else begin
            // The edge cycle counts as the first cycle of the start bit.
            state_next   = START;
            clk_cnt_next = 8'd1;
          end
        end
      end

      START: begin
        if (clk_cnt_reg != HALF_CNT) begin
          clk_cnt_next = clk_cnt_reg + 8'd1;
        end else if (!line) begin
          state_next   = DATA;
          clk_cnt_next = 8'd0;
          bit_idx_next = 3'd0;
        end else begin
          // The line was high again at mid-bit, so the low level was a glitch.
          // Drop back to IDLE without producing any pulse.
          state_next   = IDLE;
          clk_cnt_next = 8'd0;
        end
      end

      DATA: begin
        if (clk_cnt_reg != LAST_CNT) begin
          clk_cnt_next = clk_cnt_reg + 8'd1;
        end else begin
          shift_data_next[bit_idx_reg] = line;
          clk_cnt_next                 = 8'd0;
          if (bit_idx_reg == 3'd7) begin
            bit_idx_next = 3'd0;
            state_next   = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end

      STOP: begin
        if (clk_cnt_reg != LAST_CNT) begin
          clk_cnt_next = clk_cnt_reg + 8'd1;
        end else begin
          // Return to IDLE straight away, without waiting for the rest of
          // the stop bit. A following start edge is then not missed, even
          // when the frames arrive back to back.
          state_next   = IDLE;
          clk_cnt_next = 8'd0;
          if (line) begin
            rx_data_next = shift_data_reg;
            valid_next   = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end

      default: begin
        state_next   = IDLE;
        clk_cnt_next = 8'd0;
        bit_idx_next = 3'd0;
      end
    endcase
  end

  assign out_Rx_8bitData  = rx_data_reg;
  assign out_Rx_Valid     = valid_reg;
  assign out_Rx_Frame_Err = frame_err_reg;
  assign out_Rx_Active    = (state_reg != IDLE);

endmodule

// File: tb/tb_glenn_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_glenn_uart_rx
//
// Directed bench for glenn_uart_rx. It has four receiver instances, one for
// each of CLKS_PER_BIT = 1, 4, 8 and 16. The instances share the clock and
// the reset. The bench drives one serial line at a time, selected by sel.
// The other lines stay at idle (1).
// A monitor counts the Valid and Frame_Err pulses of each instance. It also
// logs the bytes that instance 1 receives and tracks how long Active stays
// high on instance 2. The directed steps compare these results with
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_glenn_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       drv;
  int         sel;
  logic       ser [4];
  logic [7:0] dat [4];
  logic       vld [4];
  logic       act [4];
  logic       fe  [4];

  int         passed;
  int         total;

  int         vcnt  [4];
  int         fecnt [4];
  int         both_cnt;
  int         act_run2;
  int         act_max2;
  logic [7:0] rxq [$];

  // These are the offsets of the bit boundaries, in clocks, for bits 0..10.
  // Boundary 0 is the start edge.
  int zero_offs  [11];
  int skew_offs  [11] = '{0, 3, -3, 2, -2, 3, -1, -3, 1, 3, 0};
  int short_stop [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    assign ser[gi] = (sel == gi) ? drv : 1'b1;

    glenn_uart_rx #(
      .CLKS_PER_BIT((gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 8 : 16)
    ) u_dut (
      .in_UART_Clock   (clk),
      .in_Reset_n      (rst_n),
      .in_Rx_Serial    (ser[gi]),
      .out_Rx_8bitData (dat[gi]),
      .out_Rx_Valid    (vld[gi]),
      .out_Rx_Active   (act[gi]),
      .out_Rx_Frame_Err(fe[gi])
    );
  end

  // Pulse monitor. It samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i]) vcnt[i] <= vcnt[i] + 1;
      if (fe[i]) fecnt[i] <= fecnt[i] + 1;
      if (vld[i] && fe[i]) both_cnt <= both_cnt + 1;
    end
    if (vld[1]) rxq.push_back(dat[1]);
    if (act[2]) begin
      act_run2 <= act_run2 + 1;
      if (act_run2 + 1 > act_max2) act_max2 <= act_run2 + 1;
    end else begin
      act_run2 <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    drv = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // This task sends one 8N1 frame on line idx. Bit k is held for
  // cpb + offs[k+1] - offs[k] clocks. It is called on a falling edge
  // and returns on a falling edge, with the line back at idle.
  task automatic send_skew(input int idx, input logic [7:0] b, input logic stop,
                           input int cpb, input int offs[11]);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    sel  = idx;
    for (int k = 0; k < 10; k++) begin
      drv = bits[k];
      repeat (cpb + offs[k+1] - offs[k]) @(negedge clk);
    end
    drv = 1'b1;
    $display("sent line %0d byte %02h stop %0b cpb %0d", idx, b, stop, cpb);
  endtask

  task automatic send_frame(input int idx, input logic [7:0] b, input int cpb);
    send_skew(idx, b, 1'b1, cpb, zero_offs);
  endtask

  int         v0;
  int         f0;
  logic [9:0] bits1;
  logic [7:0] partial;

  initial begin
    passed = 0;
    total  = 0;
    sel    = 0;
    drv    = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);

    // Check the state of the instances while reset is held.
    check("rst_data0", {24'd0, dat[0]}, 32'h00);
    check("rst_valid0", {31'd0, vld[0]}, 32'd0);
    check("rst_active0", {31'd0, act[0]}, 32'd0);
    check("rst_ferr0", {31'd0, fe[0]}, 32'd0);
    check("rst_active3", {31'd0, act[3]}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Test 1: CLKS_PER_BIT=1, byte A5. The Valid pulse is expected in the
    // cycle after the 12th rising edge that follows the start edge.
    v0    = vcnt[0];
    f0    = fecnt[0];
    sel   = 0;
    bits1 = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 14; k++) begin
      if (k == 11) check("t1_valid_edge11", {31'd0, vld[0]}, 32'd0);
      if (k == 12) begin
        check("t1_valid_edge12", {31'd0, vld[0]}, 32'd1);
        check("t1_data", {24'd0, dat[0]}, 32'hA5);
      end
      if (k == 13) check("t1_valid_edge13", {31'd0, vld[0]}, 32'd0);
      drv = (k < 10) ? bits1[k] : 1'b1;
      @(negedge clk);
    end
    idle(4);
    check("t1_valid_count", vcnt[0] - v0, 32'd1);
    check("t1_ferr_count", fecnt[0] - f0, 32'd0);

    // Test 2: CLKS_PER_BIT=4. Three frames are sent back to back.
    rxq.delete();
    f0 = fecnt[1];
    send_frame(1, 8'h00, 4);
    send_frame(1, 8'hFF, 4);
    send_frame(1, 8'h3C, 4);
    idle(12);
    check("t2_count", rxq.size(), 32'd3);
    if (rxq.size() == 3) begin
      check("t2_byte0", {24'd0, rxq[0]}, 32'h00);
      check("t2_byte1", {24'd0, rxq[1]}, 32'hFF);
      check("t2_byte2", {24'd0, rxq[2]}, 32'h3C);
    end
    check("t2_ferr_count", fecnt[1] - f0, 32'd0);

    // Load A5 into the held byte before the framing-error case.
    send_frame(1, 8'hA5, 4);
    idle(10);
    check("t4_pre_data", {24'd0, dat[1]}, 32'hA5);

    // Test 4: byte 81 with a stop bit of 0. The low stop bit lasts 2 clocks.
    // That covers the sample point, but the line is high again before the
    // receiver could take the low level as a new start bit.
    v0 = vcnt[1];
    f0 = fecnt[1];
    send_skew(1, 8'h81, 1'b0, 4, short_stop);
    idle(12);
    check("t4_ferr_count", fecnt[1] - f0, 32'd1);
    check("t4_valid_count", vcnt[1] - v0, 32'd0);
    check("t4_data_held", {24'd0, dat[1]}, 32'hA5);

    // Test 3: CLKS_PER_BIT=8. The line goes low for 2 clocks only.
    v0  = vcnt[2];
    f0  = fecnt[2];
    sel = 2;
    drv = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    check("t3_active_seen", {31'd0, act_max2 >= 1}, 32'd1);
    check("t3_active_le4", {31'd0, act_max2 <= 4}, 32'd1);
    check("t3_active_now", {31'd0, act[2]}, 32'd0);
    check("t3_valid_count", vcnt[2] - v0, 32'd0);
    check("t3_ferr_count", fecnt[2] - f0, 32'd0);

    // Test 5: CLKS_PER_BIT=4. Reset is asserted during data bit 3.
    v0      = vcnt[1];
    f0      = fecnt[1];
    sel     = 1;
    partial = 8'h0F;
    drv     = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drv = partial[k];
      repeat (4) @(negedge clk);
    end
    drv = partial[3];
    repeat (2) @(negedge clk);
    check("t5_active_mid", {31'd0, act[1]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_active_rst", {31'd0, act[1]}, 32'd0);
    check("t5_data_rst", {24'd0, dat[1]}, 32'h00);
    check("t5_valid_rst", {31'd0, vld[1]}, 32'd0);
    check("t5_ferr_rst", {31'd0, fe[1]}, 32'd0);
    drv = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    check("t5_no_valid", vcnt[1] - v0, 32'd0);
    check("t5_no_ferr", fecnt[1] - f0, 32'd0);
    send_frame(1, 8'h5A, 4);
    idle(10);
    check("t5_data_after", {24'd0, dat[1]}, 32'h5A);
    check("t5_valid_count", vcnt[1] - v0, 32'd1);

    // Test 6: CLKS_PER_BIT=16. Byte C3 is sent with up to +/-3 clocks of
    // skew on each bit boundary.
    v0 = vcnt[3];
    f0 = fecnt[3];
    send_skew(3, 8'hC3, 1'b1, 16, skew_offs);
    idle(25);
    check("t6_data", {24'd0, dat[3]}, 32'hC3);
    check("t6_valid_count", vcnt[3] - v0, 32'd1);
    check("t6_ferr_count", fecnt[3] - f0, 32'd0);

    // Valid and Frame_Err were never high together on any instance.
    check("never_both", both_cnt, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
